// File: rtl/score_matrix_ram.sv
// ============================================================================
// Module : score_matrix_ram
// Brief  : Dynamic-programming score matrix storage with a gap-score init
//          sequencer for row 0 and column 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module score_matrix_ram #(
    parameter int N_ROWS = 128,
    parameter int N_COLS = 128,
    parameter int W      = 9,
    parameter int GAP    = -1,
    parameter int RW     = $clog2(N_ROWS + 1),
    parameter int CW     = $clog2(N_COLS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_start,
    output logic          init_busy,
    output logic          init_done,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_row,
    input  logic [CW-1:0] wr_col,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [W-1:0]  rd_data,
    output logic          rd_valid,
    output logic          addr_err
);

    localparam int DEPTH = (N_ROWS + 1) * (N_COLS + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNTW  = (RW > CW) ? RW : CW;
    localparam int C_MAX = (1 << (W - 1)) - 1;
    localparam int C_MIN = -(1 << (W - 1));
    localparam logic [CNTW-1:0] C_LAST_COL = CNTW'(N_COLS);
    localparam logic [CNTW-1:0] C_LAST_ROW = CNTW'(N_ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        COL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [W-1:0]      mem [DEPTH];

    logic              w_init_we;
    logic [RW-1:0]     w_init_row;
    logic [CW-1:0]     w_init_col;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_sat;
    logic [W-1:0]      w_init_data;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_ext_we;
    logic              w_wr_err;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [AW-1:0]     w_raddr;
    logic [W-1:0]      w_wdata;

    function automatic logic [AW-1:0] lin_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(r) * AW'(N_COLS + 1) + AW'(c);
    endfunction

    // Gap score = index * GAP, clamped to the signed W-bit range
    always_comb begin
        w_prod = $signed(32'(r_cnt)) * GAP;
        w_sat  = w_prod;
        if (w_prod > C_MAX) begin
            w_sat = C_MAX;
        end else if (w_prod < C_MIN) begin
            w_sat = C_MIN;
        end
        w_init_data = w_sat[W-1:0];
    end

    always_comb begin
        w_init_we  = (r_state == ROW) || (r_state == COL);
        w_init_row = (r_state == COL) ? RW'(r_cnt) : '0;
        w_init_col = (r_state == ROW) ? CW'(r_cnt) : '0;
    end

    always_comb begin
        w_wr_in_range = (32'(wr_row) <= N_ROWS) && (32'(wr_col) <= N_COLS);
        w_rd_in_range = (32'(rd_row) <= N_ROWS) && (32'(rd_col) <= N_COLS);
        w_ext_we      = wr_en && !w_init_we && w_wr_in_range;
        w_wr_err      = wr_en && !w_init_we && !w_wr_in_range;
        w_we          = w_init_we || w_ext_we;
        w_waddr       = w_init_we ? lin_addr(w_init_row, w_init_col) : lin_addr(wr_row, wr_col);
        w_wdata       = w_init_we ? w_init_data : wr_data;
        w_raddr       = lin_addr(rd_row, rd_col);
    end

    // Storage is deliberately not reset so matrix contents survive rst
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            addr_err <= w_wr_err || (rd_en && !w_rd_in_range);
            if (rd_en) begin
                if (!w_rd_in_range) begin
                    rd_data <= '0;
                end else if (w_we && (w_waddr == w_raddr)) begin
                    rd_data <= w_wdata;
                end else begin
                    rd_data <= mem[w_raddr];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (init_start) begin
                        r_state   <= ROW;
                        r_cnt     <= '0;
                        init_busy <= 1'b1;
                    end
                end
                ROW: begin
                    if (r_cnt == C_LAST_COL) begin
                        r_state <= COL;
                        r_cnt   <= CNTW'(1);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                COL: begin
                    if (r_cnt == C_LAST_ROW) begin
                        r_state   <= DONE;
                        r_cnt     <= '0;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    init_done <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    init_busy <= 1'b0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_score_matrix_ram.sv
// ============================================================================
// Module : tb_score_matrix_ram
// Brief  : Directed self-checking bench for score_matrix_ram (4x4, GAP=-2)
//          plus a narrow W=4, GAP=-3 instance for saturation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_score_matrix_ram;

    localparam int N   = 4;
    localparam int W   = 9;
    localparam int GAP = -2;

    logic         clk = 1'b0;
    logic         rst;
    logic         init_start, init_busy, init_done;
    logic         wr_en, rd_en, rd_valid, addr_err;
    logic [2:0]   wr_row, wr_col, rd_row, rd_col;
    logic [W-1:0] wr_data, rd_data;

    logic         s_init_start, s_init_busy, s_init_done;
    logic         s_rd_en, s_rd_valid, s_addr_err;
    logic [2:0]   s_rd_row, s_rd_col;
    logic [3:0]   s_rd_data;

    int checks = 0;
    int errors = 0;
    int busy_n, done_n, err_n;

    score_matrix_ram #(.N_ROWS(N), .N_COLS(N), .W(W), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_valid(rd_valid), .addr_err(addr_err)
    );

    score_matrix_ram #(.N_ROWS(N), .N_COLS(N), .W(4), .GAP(-3)) dut_sat (
        .clk(clk), .rst(rst),
        .init_start(s_init_start), .init_busy(s_init_busy), .init_done(s_init_done),
        .wr_en(1'b0), .wr_row(3'd0), .wr_col(3'd0), .wr_data(4'd0),
        .rd_en(s_rd_en), .rd_row(s_rd_row), .rd_col(s_rd_col),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .addr_err(s_addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int r, input int c, input int d);
        wr_en = 1'b1; wr_row = 3'(r); wr_col = 3'(c); wr_data = W'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int r, input int c, input int exp);
        rd_en = 1'b1; rd_row = 3'(r); rd_col = 3'(c);
        tick();
        rd_en = 1'b0;
        chk(tag, 32'($signed(rd_data)), exp);
        chk({tag, "_valid"}, 32'(rd_valid), 1);
    endtask

    task automatic rd_sat(input string tag, input int r, input int c, input int exp);
        s_rd_en = 1'b1; s_rd_row = 3'(r); s_rd_col = 3'(c);
        tick();
        s_rd_en = 1'b0;
        chk(tag, 32'($signed(s_rd_data)), exp);
    endtask

    initial begin
        rst = 1'b1; init_start = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0; rd_row = '0; rd_col = '0;
        s_init_start = 1'b0; s_rd_en = 1'b0; s_rd_row = '0; s_rd_col = '0;
        tick(); tick();
        chk("rst_rd_data", 32'($signed(rd_data)), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_busy", 32'(init_busy), 0);
        chk("rst_done", 32'(init_done), 0);
        chk("rst_addr_err", 32'(addr_err), 0);
        rst = 1'b0;
        tick();

        // Seed (3,3) so the dropped write during init has a known prior value
        wr(3, 3, 11);

        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        busy_n = 0; done_n = 0; err_n = 0;
        for (int i = 0; i < 14; i++) begin
            busy_n += int'(init_busy);
            done_n += int'(init_done);
            err_n  += int'(addr_err);
            if (i == 2) begin
                wr_en = 1'b1; wr_row = 3'd3; wr_col = 3'd3; wr_data = W'(99);
            end else if (i == 3) begin
                wr_row = 3'd5; wr_col = 3'd0; wr_data = W'(12);
            end else if (i == 4) begin
                wr_en = 1'b0; init_start = 1'b1;
            end else if (i == 5) begin
                init_start = 1'b0;
            end
            tick();
        end
        chk("init_busy_cycles", busy_n, 9);
        chk("init_done_pulses", done_n, 1);
        chk("init_no_addr_err", err_n, 0);

        for (int c = 0; c <= N; c++) rd_chk("init_row0", 0, c, c * GAP);
        for (int r = 1; r <= N; r++) rd_chk("init_col0", r, 0, r * GAP);
        rd_chk("drop_during_init", 3, 3, 11);
        tick();
        chk("idle_rd_valid", 32'(rd_valid), 0);
        chk("hold_rd_data", 32'($signed(rd_data)), 11);

        wr(2, 3, 37);
        rd_chk("wr_then_rd", 2, 3, 37);

        wr_en = 1'b1; wr_row = 3'd1; wr_col = 3'd1; wr_data = W'(-5);
        rd_en = 1'b1; rd_row = 3'd1; rd_col = 3'd1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("bypass_ext", 32'($signed(rd_data)), -5);
        rd_chk("bypass_stored", 1, 1, -5);

        wr_en = 1'b1; wr_row = 3'd5; wr_col = 3'd0; wr_data = W'(12);
        tick();
        wr_en = 1'b0;
        chk("oor_wr_err", 32'(addr_err), 1);
        tick();
        chk("oor_wr_err_pulse", 32'(addr_err), 0);
        rd_chk("oor_wr_no_change", 4, 0, -8);
        rd_chk("oor_wr_no_change00", 0, 0, 0);

        rd_en = 1'b1; rd_row = 3'd0; rd_col = 3'd5;
        tick();
        rd_en = 1'b0;
        chk("oor_rd_data", 32'($signed(rd_data)), 0);
        chk("oor_rd_valid", 32'(rd_valid), 1);
        chk("oor_rd_err", 32'(addr_err), 1);

        // Distinct values so init overwrites and reset cut-off are visible
        wr(0, 1, 20);
        wr(2, 0, 21);
        wr(3, 0, 55);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        rd_en = 1'b1; rd_row = 3'd0; rd_col = 3'd1;
        tick();
        rd_en = 1'b0;
        chk("bypass_init", 32'($signed(rd_data)), -2);
        repeat (4) tick();
        chk("busy_before_rst", 32'(init_busy), 1);
        rst = 1'b1; rd_en = 1'b1;
        #1;
        chk("midrst_rd_data", 32'($signed(rd_data)), 0);
        chk("midrst_busy", 32'(init_busy), 0);
        chk("midrst_done", 32'(init_done), 0);
        chk("midrst_addr_err", 32'(addr_err), 0);
        tick();
        chk("midrst_rd_valid", 32'(rd_valid), 0);
        rst = 1'b0; rd_en = 1'b0;
        busy_n = 0;
        repeat (6) begin
            tick();
            busy_n += int'(init_busy);
        end
        chk("no_resume_busy", busy_n, 0);
        rd_chk("rst_kept_1_0", 1, 0, -2);
        rd_chk("rst_untouched_2_0", 2, 0, 21);
        rd_chk("rst_untouched_3_0", 3, 0, 55);
        rd_chk("rst_kept_0_4", 0, 4, -8);

        s_init_start = 1'b1;
        tick();
        s_init_start = 1'b0;
        repeat (12) tick();
        rd_sat("sat_0_1", 0, 1, -3);
        rd_sat("sat_0_2", 0, 2, -6);
        rd_sat("sat_0_3", 0, 3, -8);
        rd_sat("sat_0_4", 0, 4, -8);
        rd_sat("sat_4_0", 4, 0, -8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
